// File: rtl/ap_prof_pkg.sv
// ap_prof_pkg: shared types and helpers for the ap_ctrl transaction profiler.
//   prof_state_e : profiler FSM states (IDLE, RUN, HOLD)
//   prof_rec_t   : 96-bit record {txn_id, latency, iter_cnt, max_iter_len, hold_cnt}
//   LAT_W/CNT_W  : field widths
//   sat_inc_*    : saturating increments for latency- and count-width values
package ap_prof_pkg;

  localparam int LAT_W = 32;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} prof_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] txn_id;
    logic [LAT_W-1:0] latency;
    logic [CNT_W-1:0] iter_cnt;
    logic [CNT_W-1:0] max_iter_len;
    logic [CNT_W-1:0] hold_cnt;
  } prof_rec_t;

  function automatic logic [LAT_W-1:0] sat_inc_lat(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + LAT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/prof_rec_fifo.sv
// prof_rec_fifo: small synchronous record FIFO.
//   clock, reset : clock, async active-high reset (flushes pointers)
//   push, wdata  : write request; taken when not full or when popping same cycle
//   pop          : read request; ignored when empty
//   rdata        : head entry, forced to zero while empty
//   full, empty  : occupancy flags
module prof_rec_fifo
  import ap_prof_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = prof_rec_t
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         wr, rd;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign rdata = empty ? T'('0) : mem[rp[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + (AW+1)'(1);
      if (rd) rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ap_txn_profiler.sv
// ap_txn_profiler: watches an HLS block's ap_ctrl handshake and one-hot FSM
// state and emits one performance record per transaction into a FIFO.
//   clock, reset          : clock, async active-high reset (release synchronised upstream)
//   ap_start/ap_ready/ap_done/ap_continue : observed handshake
//   cur_state             : observed one-hot FSM state
//   rec_valid/rec_ready/rec_data : record drain port (head of FIFO)
//   busy                  : FSM in RUN or HOLD
//   ready_cnt, drop_cnt   : saturating ap_ready / dropped-record counts
//   overflow              : sticky, a record was dropped
// Optional: define AP_TXN_PROFILER_HOLD_CNT_EN to build the done-hold counter;
// without it the hold_cnt field reads 0.
module ap_txn_profiler
  import ap_prof_pkg::*;
#(
  parameter int NUM_STATES     = 150,
  parameter int ITER_START_IDX = 1,
  parameter int QUIT_IDX       = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  input  logic                  ap_continue,
  input  logic [NUM_STATES-1:0] cur_state,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [95:0]           rec_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      ready_cnt,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  overflow
);

  localparam bit SAME_IDX = (ITER_START_IDX == QUIT_IDX);

  prof_state_e      state, state_n;
  logic [LAT_W-1:0] lat;
  logic [CNT_W-1:0] ent_cnt, max_len, iter_len, txn_id;
  logic             it_open, it_prev, q_prev;

  logic             txn_start, active, it_ent, q_ent, done_now, emit, restart;
  logic             fifo_full, fifo_empty, pop, accept, drop;
  logic [CNT_W-1:0] b_ent, b_max, b_len, e_ent, e_max, e_len;
  logic [CNT_W-1:0] rec_iter, rec_hold;
  logic             b_open, e_open;
  prof_rec_t        rec, head;
  logic             unused_state_bits;

  assign unused_state_bits = ^cur_state;

  assign txn_start = (state == IDLE) && ap_start;
  assign active    = (state != IDLE) || ap_start;
  assign it_ent    = active && cur_state[ITER_START_IDX] && !it_prev;
  assign q_ent     = active && cur_state[QUIT_IDX] && !q_prev;
  // Done seen in RUN, or in the same cycle as the start.
  assign done_now  = ap_done && ((state == RUN) || txn_start);
  assign emit      = (done_now || (state == HOLD)) && ap_continue;
  assign restart   = emit && ap_start && (state != IDLE);

  // Iteration bookkeeping for this cycle. A fresh start begins from zero;
  // the resulting e_* values feed both the record and the registers.
  always_comb begin
    b_ent  = txn_start ? '0 : ent_cnt;
    b_max  = txn_start ? '0 : max_len;
    b_len  = txn_start ? '0 : iter_len;
    b_open = txn_start ? 1'b0 : it_open;
    e_ent  = b_ent;
    e_max  = b_max;
    e_len  = (state != IDLE) ? sat_inc_cnt(b_len) : b_len;
    e_open = b_open;
    if ((it_ent || q_ent) && b_open && (b_len > b_max)) e_max = b_len;
    if (q_ent) e_open = 1'b0;
    if (it_ent) begin
      e_ent  = sat_inc_cnt(b_ent);
      e_len  = CNT_W'(1);
      e_open = 1'b1;
    end
  end

  // With a shared start/quit index the exiting pass is not an iteration.
  always_comb begin
    if (SAME_IDX) rec_iter = (e_ent == '0) ? '0 : e_ent - CNT_W'(1);
    else          rec_iter = e_ent;
  end

`ifdef AP_TXN_PROFILER_HOLD_CNT_EN
  logic [CNT_W-1:0] hold_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             hold_q <= '0;
    else if (done_now && !ap_continue)     hold_q <= CNT_W'(1);
    else if (state == HOLD && !ap_continue) hold_q <= sat_inc_cnt(hold_q);
  end
  assign rec_hold = (state == HOLD) ? hold_q : '0;
`else
  assign rec_hold = '0;
`endif

  always_comb begin
    rec.txn_id       = txn_id;
    rec.latency      = (state == IDLE) ? '0 : lat;
    rec.iter_cnt     = rec_iter;
    rec.max_iter_len = e_max;
    rec.hold_cnt     = rec_hold;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (ap_start) state_n = ap_done ? (ap_continue ? IDLE : HOLD) : RUN;
      RUN:     if (ap_done) state_n = !ap_continue ? HOLD : (ap_start ? RUN : IDLE);
      HOLD:    if (ap_continue) state_n = ap_start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat      <= '0;
      ent_cnt  <= '0;
      max_len  <= '0;
      iter_len <= '0;
      it_open  <= 1'b0;
      it_prev  <= 1'b0;
      q_prev   <= 1'b0;
    end else begin
      it_prev <= cur_state[ITER_START_IDX];
      q_prev  <= cur_state[QUIT_IDX];
      // Start cycle is index 0, so the next cycle reads 1; a same-cycle
      // done freezes latency at 0.
      if (restart)                        lat <= LAT_W'(1);
      else if (txn_start)                 lat <= ap_done ? '0 : LAT_W'(1);
      else if (state == RUN && !ap_done)  lat <= sat_inc_lat(lat);
      // Events on the done cycle belong to the finishing record.
      if (restart) begin
        ent_cnt  <= '0;
        max_len  <= '0;
        iter_len <= '0;
        it_open  <= 1'b0;
      end else begin
        ent_cnt  <= e_ent;
        max_len  <= e_max;
        iter_len <= e_len;
        it_open  <= e_open;
      end
    end
  end

  assign rec_valid = !fifo_empty;
  assign pop       = rec_valid && rec_ready;
  assign accept    = emit && (!fifo_full || pop);
  assign drop      = emit && !accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txn_id    <= '0;
      ready_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (emit)     txn_id    <= txn_id + CNT_W'(1);
      if (ap_ready) ready_cnt <= sat_inc_cnt(ready_cnt);
      if (drop) begin
        drop_cnt <= sat_inc_cnt(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

  prof_rec_fifo #(.DEPTH(FIFO_DEPTH), .T(prof_rec_t)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .wdata (rec),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rec_data = head;

endmodule

// File: tb/tb_ap_txn_profiler.sv
module tb_ap_txn_profiler;

`ifdef AP_TXN_PROFILER_HOLD_CNT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset, ap_start, ap_ready, ap_done, ap_continue, rec_ready;
  logic [149:0] cur_state;
  logic         rec_valid, busy, overflow;
  logic [95:0]  rec_data;
  logic [15:0]  ready_cnt, drop_cnt;

  int tests = 0;
  int fails = 0;

  ap_txn_profiler dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .cur_state(cur_state),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .busy(busy), .ready_cnt(ready_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_state(input bit in_iter);
    cur_state = '0;
    if (in_iter) cur_state[1] = 1'b1;
    else         cur_state[0] = 1'b1;
  endtask

  task automatic idle_inputs();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    set_state(1'b0);
  endtask

  function automatic logic [95:0] mkrec(input int id, input int lat, input int it,
                                        input int mx, input int hd);
    return {16'(id), 32'(lat), 16'(it), 16'(mx), 16'(hd)};
  endfunction

  // One transaction: start at k=0, done at k=lat, continue at k=lat+hold;
  // ITER_START (state 1) pulsed at off + j*period.
  task automatic run_txn(input int lat, input int hold, input int n_ent,
                         input int period, input int off, output bit busy_ok);
    bit ent;
    busy_ok = 1;
    for (int k = 0; k <= lat + hold; k++) begin
      ap_start    = (k == 0);
      ap_done     = (k >= lat);
      ap_continue = (k == lat + hold);
      ap_ready    = (k == lat);
      ent = 0;
      for (int j = 0; j < n_ent; j++) if (k == off + j * period) ent = 1;
      set_state(ent);
      tick();
      if (k < lat + hold && busy !== 1'b1) busy_ok = 0;
    end
    idle_inputs();
  endtask

  task automatic pop_chk(input string name, input logic [95:0] exp);
    chk({name, "_valid"}, 96'(rec_valid), 96'(1));
    chk({name, "_data"}, rec_data, exp);
    rec_ready = 1;
    tick();
    rec_ready = 0;
  endtask

  typedef struct {
    int lat; int hold; int n_ent; int period; int off;
    int e_iter; int e_max; int e_hold;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit ok;
    vecs[0] = '{149, 0, 0,   0, 0, 0,   0, 0};
    vecs[1] = '{450, 0, 4, 149, 1, 3, 149, 0};
    vecs[2] = '{ 50, 7, 0,   0, 0, 0,   0, HOLD_EN ? 7 : 0};
    vecs[3] = '{ 20, 0, 3,   5, 2, 2,   5, 0};
    vecs[4] = '{  1, 2, 1,   0, 0, 0,   0, HOLD_EN ? 2 : 0};
    vecs[5] = '{  0, 0, 0,   0, 0, 0,   0, 0};

    reset = 1; rec_ready = 0;
    idle_inputs();
    tick(); tick();
    chk("reset_outs", {rec_valid, busy, overflow, ready_cnt, drop_cnt, rec_data},
        {3'b000, 16'd0, 16'd0, 96'd0});
    reset = 0;
    repeat (9) tick();

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].lat, vecs[i].hold, vecs[i].n_ent, vecs[i].period, vecs[i].off, ok);
      chk($sformatf("v%0d_busy_run", i), 96'(ok), 96'(1));
      chk($sformatf("v%0d_busy_idle", i), 96'(busy), 96'(0));
      pop_chk($sformatf("v%0d_rec", i),
              mkrec(i, vecs[i].lat, vecs[i].e_iter, vecs[i].e_max, vecs[i].e_hold));
      repeat (3) tick();
    end
    chk("ready_cnt", 96'(ready_cnt), 96'(6));
    chk("no_drop", {94'(drop_cnt), 1'b0, overflow}, 96'(0));

    // Overflow: six transactions with nothing draining a 4-deep FIFO.
    reset = 1; tick(); reset = 0; tick();
    for (int i = 0; i < 6; i++) begin
      run_txn(3, 0, 0, 0, 0, ok);
      tick();
    end
    chk("ovf_drop_cnt", 96'(drop_cnt), 96'(2));
    chk("ovf_flag", 96'(overflow), 96'(1));
    tick(); tick();
    for (int i = 0; i < 4; i++) pop_chk($sformatf("ovf_rec%0d", i), mkrec(i, 3, 0, 0, 0));
    chk("ovf_empty", 96'(rec_valid), 96'(0));

    // Back-to-back: done and new start together at k=5, second done at k=13.
    for (int k = 0; k <= 13; k++) begin
      ap_start    = (k == 0 || k == 5);
      ap_done     = (k == 5 || k == 13);
      ap_continue = ap_done;
      tick();
      if (k == 5) chk("b2b_busy", 96'(busy), 96'(1));
    end
    idle_inputs();
    chk("b2b_idle", 96'(busy), 96'(0));
    pop_chk("b2b_rec0", mkrec(6, 5, 0, 0, 0));
    pop_chk("b2b_rec1", mkrec(7, 8, 0, 0, 0));

    // Reset mid-RUN with two records queued.
    run_txn(4, 0, 0, 0, 0, ok);
    run_txn(4, 0, 0, 0, 0, ok);
    ap_start = 1; tick(); ap_start = 0;
    tick(); tick();
    chk("mid_busy", 96'(busy), 96'(1));
    reset = 1;
    #1;
    chk("rst_outs", {rec_valid, busy, overflow, ready_cnt, drop_cnt},
        {3'b000, 16'd0, 16'd0});
    tick();
    reset = 0;
    run_txn(2, 0, 0, 0, 0, ok);
    pop_chk("post_rst_rec", mkrec(0, 2, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
